// File: rtl/alu_decode_stage.sv
// RV32I/M instruction decoder feeding a one-entry output register; divide and
// remainder entries are held back for a fixed number of cycles before release.
module alu_decode_stage #(
  parameter int EN_M       = 1,
  parameter int DIV_CYCLES = 8,
  parameter int ALUOP_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ALUOP_W-1:0] alu_control,
  output logic               data_type,
  output logic [1:0]         data_size,
  output logic               is_muldiv,
  output logic               illegal,
  output logic               busy
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [4:0] DIV_LOAD = 5'(DIV_CYCLES - 1);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [6:0] funct7_s;
  logic       unused_s;

  logic [4:0] dec_code_s;
  logic       dec_dt_s;
  logic [1:0] dec_ds_s;
  logic       dec_md_s;
  logic       dec_ill_s;
  logic       dec_div_s;

  logic [1:0] state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] code_q;
  logic       dt_q, md_q, ill_q;
  logic [1:0] ds_q;
  logic       accept_s;
  logic       load_s;

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  assign funct7_s = instr[31:25];
  assign unused_s = ^{instr[24:15], instr[11:7]};

  // Instruction decode; illegal encodings collapse to the neutral field set.
  always_comb begin
    dec_code_s = 5'b00000;
    dec_dt_s   = 1'b0;
    dec_ds_s   = 2'b10;
    dec_md_s   = 1'b0;
    dec_ill_s  = 1'b0;
    case (opcode_s)
      OP_REG: begin
        if (funct7_s == 7'b0000000) begin
          case (funct3_s)
            3'b000:  dec_code_s = 5'b00000;
            3'b001:  dec_code_s = 5'b00010;
            3'b010:  dec_code_s = 5'b00011;
            3'b011:  dec_code_s = 5'b00100;
            3'b100:  dec_code_s = 5'b00101;
            3'b101:  dec_code_s = 5'b00110;
            3'b110:  dec_code_s = 5'b01000;
            3'b111:  dec_code_s = 5'b01001;
            default: dec_ill_s  = 1'b1;
          endcase
        end else if (funct7_s == 7'b0100000) begin
          case (funct3_s)
            3'b000:  dec_code_s = 5'b00001;
            3'b101:  dec_code_s = 5'b00111;
            default: dec_ill_s  = 1'b1;
          endcase
        end else if ((funct7_s == 7'b0000001) && (EN_M != 0)) begin
          dec_md_s = 1'b1;
          case (funct3_s)
            3'b000:  dec_code_s = 5'b10011;
            3'b001:  dec_code_s = 5'b10100;
            3'b010:  dec_code_s = 5'b10101;
            3'b011:  dec_code_s = 5'b10110;
            3'b100:  dec_code_s = 5'b10111;
            3'b101:  dec_code_s = 5'b11001;
            3'b110:  dec_code_s = 5'b11010;
            3'b111:  dec_code_s = 5'b11011;
            default: dec_ill_s  = 1'b1;
          endcase
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      OP_IMM: begin
        case (funct3_s)
          3'b000: dec_code_s = 5'b00000;
          3'b010: dec_code_s = 5'b00011;
          3'b011: dec_code_s = 5'b00100;
          3'b100: dec_code_s = 5'b00101;
          3'b110: dec_code_s = 5'b01000;
          3'b111: dec_code_s = 5'b01001;
          3'b001: begin
            if (funct7_s == 7'b0000000) begin
              dec_code_s = 5'b00010;
            end else begin
              dec_ill_s = 1'b1;
            end
          end
          3'b101: begin
            if (funct7_s == 7'b0000000) begin
              dec_code_s = 5'b00110;
            end else if (funct7_s == 7'b0100000) begin
              dec_code_s = 5'b00111;
            end else begin
              dec_ill_s = 1'b1;
            end
          end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OP_LOAD: begin
        case (funct3_s)
          3'b000:  dec_ds_s = 2'b00;
          3'b001:  dec_ds_s = 2'b01;
          3'b010:  dec_ds_s = 2'b10;
          3'b100:  begin dec_ds_s = 2'b00; dec_dt_s = 1'b1; end
          3'b101:  begin dec_ds_s = 2'b01; dec_dt_s = 1'b1; end
          default: dec_ill_s = 1'b1;
        endcase
      end
      OP_STORE: begin
        case (funct3_s)
          3'b000:  dec_ds_s  = 2'b00;
          3'b001:  dec_ds_s  = 2'b01;
          3'b010:  dec_ds_s  = 2'b10;
          default: dec_ill_s = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        case (funct3_s)
          3'b000:  dec_code_s = 5'b01101;
          3'b001:  dec_code_s = 5'b01110;
          3'b100:  dec_code_s = 5'b01111;
          3'b101:  dec_code_s = 5'b10000;
          3'b110:  dec_code_s = 5'b10001;
          3'b111:  dec_code_s = 5'b10010;
          default: dec_ill_s  = 1'b1;
        endcase
      end
      OP_JAL:   dec_code_s = 5'b11000;
      OP_JALR: begin
        if (funct3_s == 3'b000) begin
          dec_code_s = 5'b11101;
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      OP_LUI:   dec_code_s = 5'b11100;
      OP_AUIPC: dec_code_s = 5'b11110;
      default:  dec_ill_s  = 1'b1;
    endcase
    if (dec_ill_s) begin
      dec_code_s = 5'b00000;
      dec_dt_s   = 1'b0;
      dec_ds_s   = 2'b10;
      dec_md_s   = 1'b0;
    end else begin
      dec_code_s = dec_code_s;
    end
  end

  // DIV/DIVU/REM/REMU are the RV32M encodings with funct3[2] set.
  assign dec_div_s = dec_md_s & funct3_s[2];

  assign in_ready = rst_n & ~flush &
                    ((state_q == ST_EMPTY) | ((state_q == ST_FULL) & out_ready));
  assign accept_s = in_valid & in_ready;

  // Next-state logic for the EMPTY/FULL/WAIT handshake and divide hold counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
      cnt_d   = 5'd0;
    end else begin
      case (state_q)
        ST_EMPTY, ST_FULL: begin
          if (accept_s) begin
            load_s = 1'b1;
            if (dec_div_s) begin
              state_d = ST_WAIT;
              cnt_d   = DIV_LOAD;
            end else begin
              state_d = ST_FULL;
              cnt_d   = 5'd0;
            end
          end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = state_q;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 5'd0) begin
            state_d = ST_FULL;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          cnt_d   = 5'd0;
        end
      endcase
    end
  end

  // State, counter and decoded-field registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= 5'd0;
      code_q  <= 5'd0;
      dt_q    <= 1'b0;
      ds_q    <= 2'b10;
      md_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load_s) begin
        code_q <= dec_code_s;
        dt_q   <= dec_dt_s;
        ds_q   <= dec_ds_s;
        md_q   <= dec_md_s;
        ill_q  <= dec_ill_s;
      end
    end
  end

  assign out_valid   = (state_q == ST_FULL);
  assign busy        = (state_q == ST_WAIT);
  assign alu_control = ALUOP_W'(code_q);
  assign data_type   = dt_q;
  assign data_size   = ds_q;
  assign is_muldiv   = md_q;
  assign illegal     = ill_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed scenarios plus random
// instructions checked against a table-driven reference decoder.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic        in_ready, out_valid, data_type, is_muldiv, illegal, busy;
  logic [4:0]  alu_control;
  logic [1:0]  data_size;
  logic        nm_in_ready, nm_out_valid, nm_data_type, nm_is_muldiv, nm_illegal, nm_busy;
  logic [4:0]  nm_alu_control;
  logic [1:0]  nm_data_size;

  int total = 0;
  int bad   = 0;

  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  logic [4:0]  t_code[$];
  logic [1:0]  t_size[$];
  bit          t_dt[$];
  bit          t_md[$];

  alu_decode_stage #(.EN_M(1), .DIV_CYCLES(8), .ALUOP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
    .data_type(data_type), .data_size(data_size), .is_muldiv(is_muldiv),
    .illegal(illegal), .busy(busy));

  alu_decode_stage #(.EN_M(0), .DIV_CYCLES(8), .ALUOP_W(5)) dut_nm (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
    .instr(instr), .out_valid(nm_out_valid), .out_ready(out_ready), .alu_control(nm_alu_control),
    .data_type(nm_data_type), .data_size(nm_data_size), .is_muldiv(nm_is_muldiv),
    .illegal(nm_illegal), .busy(nm_busy));

  always #5 clk = ~clk;

  localparam logic [31:0] M_OP = 32'h0000007F;
  localparam logic [31:0] M_F3 = 32'h0000707F;
  localparam logic [31:0] M_F7 = 32'hFE00707F;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 10'd0, f3, 5'd0, op};
  endfunction

  function void add(input logic [31:0] mask, input logic [31:0] match, input int code,
                    input int size, input bit dt, input bit md);
    t_mask.push_back(mask);
    t_match.push_back(match);
    t_code.push_back(5'(code));
    t_size.push_back(2'(size));
    t_dt.push_back(dt);
    t_md.push_back(md);
  endfunction

  // Valid-encoding table: the first matching row wins, no match means illegal.
  task automatic build_table();
    int r_f7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
    int r_f3[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int r_cd[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    int m_cd[8]  = '{19, 20, 21, 22, 23, 25, 26, 27};
    int i_f3[6]  = '{0, 2, 3, 4, 6, 7};
    int i_cd[6]  = '{0, 3, 4, 5, 8, 9};
    int b_f3[6]  = '{0, 1, 4, 5, 6, 7};
    int l_f3[5]  = '{0, 1, 2, 4, 5};
    int l_sz[5]  = '{0, 1, 2, 0, 1};
    for (int k = 0; k < 10; k++) add(M_F7, enc(7'(r_f7[k]), 3'(r_f3[k]), 7'h33), r_cd[k], 2, 0, 0);
    for (int k = 0; k < 8; k++)  add(M_F7, enc(7'h01, 3'(k), 7'h33), m_cd[k], 2, 0, 1);
    for (int k = 0; k < 6; k++)  add(M_F3, enc(7'h00, 3'(i_f3[k]), 7'h13), i_cd[k], 2, 0, 0);
    add(M_F7, enc(7'h00, 3'd1, 7'h13), 2, 2, 0, 0);
    add(M_F7, enc(7'h00, 3'd5, 7'h13), 6, 2, 0, 0);
    add(M_F7, enc(7'h20, 3'd5, 7'h13), 7, 2, 0, 0);
    for (int k = 0; k < 5; k++)  add(M_F3, enc(7'h00, 3'(l_f3[k]), 7'h03), 0, l_sz[k], (k >= 3), 0);
    for (int k = 0; k < 3; k++)  add(M_F3, enc(7'h00, 3'(k), 7'h23), 0, k, 0, 0);
    for (int k = 0; k < 6; k++)  add(M_F3, enc(7'h00, 3'(b_f3[k]), 7'h63), 13 + k, 2, 0, 0);
    add(M_OP, 32'h0000006F, 24, 2, 0, 0);
    add(M_F3, 32'h00000067, 29, 2, 0, 0);
    add(M_OP, 32'h00000037, 28, 2, 0, 0);
    add(M_OP, 32'h00000017, 30, 2, 0, 0);
  endtask

  // Returns {alu_control, data_type, data_size, is_muldiv, illegal}.
  function automatic logic [9:0] ref_dec(input logic [31:0] ins, input bit en_m);
    for (int k = 0; k < t_mask.size(); k++) begin
      if (((ins & t_mask[k]) == t_match[k]) && (en_m || !t_md[k]))
        return {t_code[k], t_dt[k], t_size[k], t_md[k], 1'b0};
    end
    return {5'd0, 1'b0, 2'b10, 1'b0, 1'b1};
  endfunction

  function automatic bit ref_is_div(input logic [31:0] ins);
    logic [9:0] f;
    f = ref_dec(ins, 1'b1);
    return f[1] && ins[14];
  endfunction

  // Issues one instruction with out_ready=1 and waits (bounded) for out_valid.
  task automatic send(input logic [31:0] ins, output int lat, output int busy_n, output int rdy_bad);
    instr = ins; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1; busy_n = 0; rdy_bad = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_n++;
      if (busy && in_ready) rdy_bad++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 32'd0;
    @(negedge clk); @(negedge clk);
    total++;
    if ({out_valid, busy, in_ready, alu_control, data_type, data_size, is_muldiv, illegal} !==
        {1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b b=%b r=%b op=%b dt=%b ds=%b md=%b il=%b",
               out_valid, busy, in_ready, alu_control, data_type, data_size, is_muldiv, illegal);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_sub();
    int lat, bn, rb;
    @(negedge clk);
    send(32'h40208033, lat, bn, rb);
    total++;
    if ({lat, alu_control, illegal} !== {32'sd1, 5'b00001, 1'b0}) begin
      bad++; $display("FAIL sub: got lat=%0d op=%b il=%b want lat=1 op=00001 il=0", lat, alu_control, illegal);
    end
  endtask

  task automatic test_load_size();
    int lat, bn, rb;
    @(negedge clk);
    send(32'h0000D083, lat, bn, rb);
    total++;
    if ({data_type, data_size, alu_control} !== {1'b1, 2'b01, 5'd0}) begin
      bad++; $display("FAIL lhu: got dt=%b ds=%b op=%b want dt=1 ds=01 op=0", data_type, data_size, alu_control);
    end
    @(negedge clk);
    send(32'h00108093, lat, bn, rb);
    total++;
    if ({data_type, data_size} !== {1'b0, 2'b10}) begin
      bad++; $display("FAIL addi_after_lhu: got dt=%b ds=%b want dt=0 ds=10", data_type, data_size);
    end
  endtask

  task automatic test_div();
    int lat, bn, rb;
    @(negedge clk);
    send(32'h0220C0B3, lat, bn, rb);
    total++;
    if ({lat, bn, rb} !== {32'sd9, 32'sd8, 32'sd0}) begin
      bad++; $display("FAIL div_timing: got lat=%0d busy=%0d ready_in_wait=%0d want 9/8/0", lat, bn, rb);
    end
    total++;
    if ({alu_control, is_muldiv, illegal} !== {5'b10111, 1'b1, 1'b0}) begin
      bad++; $display("FAIL div_fields: got op=%b md=%b il=%b want 10111/1/0", alu_control, is_muldiv, illegal);
    end
  endtask

  task automatic test_no_m();
    @(negedge clk);
    instr = 32'h022080B3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({nm_out_valid, nm_busy, nm_illegal, nm_alu_control, nm_is_muldiv} !==
        {1'b1, 1'b0, 1'b1, 5'd0, 1'b0}) begin
      bad++; $display("FAIL mul_en_m0: got v=%b b=%b il=%b op=%b md=%b want 1/0/1/0/0",
                      nm_out_valid, nm_busy, nm_illegal, nm_alu_control, nm_is_muldiv);
    end
    total++;
    if ({out_valid, alu_control, is_muldiv} !== {1'b1, 5'b10011, 1'b1}) begin
      bad++; $display("FAIL mul_en_m1: got v=%b op=%b md=%b want 1/10011/1", out_valid, alu_control, is_muldiv);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    instr = 32'h40208033; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; instr = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({out_valid, alu_control, illegal, in_ready} !== {1'b1, 5'b00001, 1'b0, 1'b0}) begin
        bad++; $display("FAIL hold_%0d: got v=%b op=%b il=%b rdy=%b want 1/00001/0/0",
                        i, out_valid, alu_control, illegal, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0010C093;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if ({out_valid, alu_control} !== {1'b1, 5'b00101}) begin
      bad++; $display("FAIL b2b_data: got v=%b op=%b want 1/00101", out_valid, alu_control);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    instr = 32'h0220C0B3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if ({busy, out_valid, in_ready} !== {1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL flush_wait: got b=%b v=%b rdy=%b want 0/0/1", busy, out_valid, in_ready);
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; instr = 32'h002081B3;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, busy} !== {1'b0, 1'b0}) begin
      bad++; $display("FAIL flush_accept: got v=%b b=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    int seen = 0;
    @(negedge clk);
    instr = 32'h0220F0B3; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, out_valid, in_ready, alu_control} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
      bad++; $display("FAIL reset_mid_wait: got b=%b v=%b rdy=%b op=%b want 0/0/0/0",
                      busy, out_valid, in_ready, alu_control);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL reset_abort: got %0d valid cycles want 0", seen); end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  ops[10] = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    int sel;
    r = $urandom;
    sel = $urandom_range(0, 10);
    if (sel < 10) r[6:0] = ops[sel];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: r[31:25] = r[31:25];
    endcase
    return r;
  endfunction

  task automatic test_random();
    logic [31:0] ins;
    logic [9:0]  exp1, exp0;
    int          lat, want_lat;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      ins  = gen_instr();
      exp1 = ref_dec(ins, 1'b1);
      exp0 = ref_dec(ins, 1'b0);
      want_lat = ref_is_div(ins) ? 9 : 1;
      instr = ins; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready[%0d]: got %b want 1", n, in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if ({nm_out_valid, nm_alu_control, nm_data_type, nm_data_size, nm_is_muldiv, nm_illegal} !== {1'b1, exp0}) begin
        bad++; $display("FAIL rnd_nom[%0d] instr=%h: got v=%b f=%b want 1 %b", n, ins, nm_out_valid,
                        {nm_alu_control, nm_data_type, nm_data_size, nm_is_muldiv, nm_illegal}, exp0);
      end
      lat = 1;
      while (!out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      total++;
      if ((out_valid !== 1'b1) || (lat != want_lat) ||
          ({alu_control, data_type, data_size, is_muldiv, illegal} !== exp1)) begin
        bad++; $display("FAIL rnd_m[%0d] instr=%h: got lat=%0d f=%b want lat=%0d f=%b", n, ins, lat,
                        {alu_control, data_type, data_size, is_muldiv, illegal}, want_lat, exp1);
      end
    end
  endtask

  initial begin
    build_table();
    test_reset();
    test_sub();
    test_load_size();
    test_div();
    test_no_m();
    test_back_to_back();
    test_flush();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
